// File: rtl/hack_alu_pkg.sv
// rtl/hack_alu_pkg.sv - op and state encodings for the sequential Hack ALU
package hack_alu_pkg;

    typedef enum logic [1:0] {
        OP_HACK = 2'b00,
        OP_MUL  = 2'b01,
        OP_SHL  = 2'b10,
        OP_SHR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/alu_preproc.sv
// rtl/alu_preproc.sv - Hack operand zeroing and bitwise negation
module alu_preproc #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_val,
    input  logic             i_z,
    input  logic             i_n,
    output logic [WIDTH-1:0] o_val
);

    logic [WIDTH-1:0] w_zeroed;

    assign w_zeroed = i_z ? '0 : i_val;
    assign o_val    = i_n ? ~w_zeroed : w_zeroed;

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle Hack ALU with iterative multiply and shifts
module seq_alu
    import hack_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    input  logic [1:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int            CW         = SHW + 1;
    localparam logic [CW-1:0] C_ONE      = CW'(1);
    localparam logic [CW-1:0] C_MUL_CNT  = CW'(WIDTH - 1);

    state_e           r_state;
    state_e           w_state_next;
    op_e              r_op;
    op_e              w_op;
    logic [WIDTH-1:0] r_px;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_out;
    logic [CW-1:0]    r_cnt;
    logic             r_no;
    logic             r_skip;

    logic [WIDTH-1:0] w_px;
    logic [WIDTH-1:0] w_py;
    logic [SHW-1:0]   w_k;
    logic [WIDTH-1:0] w_hack;
    logic [WIDTH-1:0] w_acc_next;
    logic [CW-1:0]    w_cnt_load;
    logic             w_accept;

    alu_preproc #(.WIDTH(WIDTH)) u_pre_x (
        .i_val (x),
        .i_z   (zx),
        .i_n   (nx),
        .o_val (w_px)
    );

    alu_preproc #(.WIDTH(WIDTH)) u_pre_y (
        .i_val (y),
        .i_z   (zy),
        .i_n   (ny),
        .o_val (w_py)
    );

    assign w_op     = op_e'(op);
    assign w_k      = w_py[SHW-1:0];
    assign w_hack   = f ? (w_px + w_py) : (w_px & w_py);
    assign w_accept = in_valid && in_ready;

    // Counter holds remaining BUSY cycles minus one; HACK spends a single BUSY cycle.
    always_comb begin
        w_cnt_load = '0;
        unique case (w_op)
            OP_HACK: w_cnt_load = '0;
            OP_MUL:  w_cnt_load = C_MUL_CNT;
            OP_SHL,
            OP_SHR:  w_cnt_load = (w_k == '0) ? '0 : ({1'b0, w_k} - C_ONE);
            default: w_cnt_load = '0;
        endcase
    end

    // MUL walks py MSB-first: acc = 2*acc + (bit ? px : 0).
    always_comb begin
        w_acc_next = r_acc;
        unique case (r_op)
            OP_HACK: w_acc_next = r_acc;
            OP_MUL:  w_acc_next = {r_acc[WIDTH-2:0], 1'b0} + (r_sh[WIDTH-1] ? r_px : '0);
            OP_SHL:  if (!r_skip) w_acc_next = {r_acc[WIDTH-2:0], 1'b0};
            OP_SHR:  if (!r_skip) w_acc_next = {1'b0, r_acc[WIDTH-1:1]};
            default: w_acc_next = r_acc;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_next = ST_BUSY;
            end
            ST_BUSY: begin
                if (r_cnt == '0) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) w_state_next = in_valid ? ST_BUSY : ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op   <= OP_HACK;
            r_px   <= '0;
            r_sh   <= '0;
            r_acc  <= '0;
            r_out  <= '0;
            r_cnt  <= '0;
            r_no   <= 1'b0;
            r_skip <= 1'b0;
        end else if (w_accept) begin
            r_op   <= w_op;
            r_px   <= w_px;
            r_sh   <= w_py;
            r_no   <= no;
            r_cnt  <= w_cnt_load;
            r_skip <= (w_k == '0);
            unique case (w_op)
                OP_HACK: r_acc <= w_hack;
                OP_MUL:  r_acc <= '0;
                default: r_acc <= w_px;
            endcase
        end else if (r_state == ST_BUSY) begin
            r_acc <= w_acc_next;
            r_sh  <= {r_sh[WIDTH-2:0], 1'b0};
            if (r_cnt == '0) begin
                r_out <= r_no ? ~w_acc_next : w_acc_next;
            end else begin
                r_cnt <= r_cnt - C_ONE;
            end
        end
    end

    assign out = r_out;
    assign zr  = (r_out == '0);
    assign ng  = r_out[WIDTH-1];

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - randomized self-checking bench for seq_alu
module tb_seq_alu;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] x, y;
    logic         zx, nx, zy, ny, f, no;
    logic [1:0]   op;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out;
    logic         zr, ng;
    logic         out_valid;
    logic         out_ready;

    int n_pass  = 0;
    int n_total = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .y         (y),
        .zx        (zx),
        .nx        (nx),
        .zy        (zy),
        .ny        (ny),
        .f         (f),
        .no        (no),
        .op        (op),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .zr        (zr),
        .ng        (ng),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // ctl = {zx, nx, zy, ny, f, no}
    function automatic logic [W-1:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic [5:0] ctl, input logic [1:0] o);
        logic [W-1:0]   pa, pb, r;
        logic [2*W-1:0] prod;
        pa = ctl[5] ? '0 : a;
        pa = ctl[4] ? ~pa : pa;
        pb = ctl[3] ? '0 : b;
        pb = ctl[2] ? ~pb : pb;
        prod = {{W{1'b0}}, pa} * {{W{1'b0}}, pb};
        case (o)
            2'd0:    r = ctl[1] ? pa + pb : pa & pb;
            2'd1:    r = prod[W-1:0];
            2'd2:    r = pa << pb[3:0];
            default: r = pa >> pb[3:0];
        endcase
        return ctl[0] ? ~r : r;
    endfunction

    function automatic int ref_latency(input logic [W-1:0] b, input logic [5:0] ctl, input logic [1:0] o);
        logic [W-1:0] pb;
        pb = ctl[3] ? '0 : b;
        pb = ctl[2] ? ~pb : pb;
        if (o == 2'd0) return 1;
        if (o == 2'd1) return W;
        return (pb[3:0] == 4'd0) ? 1 : int'(pb[3:0]);
    endfunction

    task automatic drive_cmd(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [5:0] ctl, input logic [1:0] o);
        x = a; y = b;
        {zx, nx, zy, ny, f, no} = ctl;
        op = o;
    endtask

    // Issues one command from a point #1 after an edge, returns when out_valid is seen.
    task automatic run_cmd(input logic [W-1:0] a, input logic [W-1:0] b, input logic [5:0] ctl,
                           input logic [1:0] o, output logic [W-1:0] ro, output logic rzr,
                           output logic rng, output int lat, output bit stall_ok);
        drive_cmd(a, b, ctl, o);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        drive_cmd(W'($urandom), W'($urandom), 6'($urandom), 2'($urandom));
        lat = 0;
        stall_ok = 1'b1;
        while (!out_valid && lat < 64) begin
            if (in_ready) stall_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        ro = out; rzr = zr; rng = ng;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        drive_cmd('0, '0, '0, 2'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        n_total++; if (out !== 16'h0000) $display("FAIL reset_out got=%h exp=0000", out); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else n_pass++;
        n_total++; if ({zr, ng} !== 2'b10) $display("FAIL reset_flags got zr,ng=%b exp=10", {zr, ng}); else n_pass++;
    endtask

    task automatic test_hack();
        logic [W-1:0] ro; logic rzr, rng; int lat; bit st;
        run_cmd(16'd5, 16'd3, 6'b000010, 2'd0, ro, rzr, rng, lat, st);
        n_total++; if (ro !== 16'd8) $display("FAIL hack_add got=%h exp=0008", ro); else n_pass++;
        n_total++; if (lat != 1) $display("FAIL hack_add_lat got=%0d exp=1", lat); else n_pass++;
        n_total++; if ({rzr, rng} !== 2'b00) $display("FAIL hack_add_flags got=%b exp=00", {rzr, rng}); else n_pass++;
        run_cmd(16'd3, 16'd5, 6'b010011, 2'd0, ro, rzr, rng, lat, st);
        n_total++; if (ro !== 16'hFFFE) $display("FAIL hack_x_minus_y got=%h exp=fffe", ro); else n_pass++;
        n_total++; if (rng !== 1'b1) $display("FAIL hack_x_minus_y_ng got=%b exp=1", rng); else n_pass++;
        run_cmd(16'h1234, 16'h5678, 6'b101010, 2'd0, ro, rzr, rng, lat, st);
        n_total++; if (ro !== 16'h0000) $display("FAIL hack_zero got=%h exp=0000", ro); else n_pass++;
        n_total++; if (rzr !== 1'b1) $display("FAIL hack_zero_zr got=%b exp=1", rzr); else n_pass++;
        run_cmd(16'h7FFF, 16'h0001, 6'b000010, 2'd0, ro, rzr, rng, lat, st);
        n_total++; if ({ro, rng} !== {16'h8000, 1'b1}) $display("FAIL hack_wrap got=%h ng=%b exp=8000 ng=1", ro, rng); else n_pass++;
    endtask

    task automatic test_mul();
        logic [W-1:0] ro; logic rzr, rng; int lat; bit st;
        run_cmd(16'd300, 16'd300, 6'b000000, 2'd1, ro, rzr, rng, lat, st);
        n_total++; if (ro !== 16'h5F90) $display("FAIL mul_300x300 got=%h exp=5f90", ro); else n_pass++;
        n_total++; if (lat != W) $display("FAIL mul_lat got=%0d exp=%0d", lat, W); else n_pass++;
        n_total++; if (st !== 1'b1) $display("FAIL mul_in_ready_stall got=%b exp=1", st); else n_pass++;
    endtask

    task automatic test_shift();
        logic [W-1:0] ro; logic rzr, rng; int lat; bit st;
        run_cmd(16'h0001, 16'd15, 6'b000000, 2'd2, ro, rzr, rng, lat, st);
        n_total++; if (ro !== 16'h8000) $display("FAIL shl15 got=%h exp=8000", ro); else n_pass++;
        n_total++; if (lat != 15) $display("FAIL shl15_lat got=%0d exp=15", lat); else n_pass++;
        run_cmd(16'h8000, 16'd4, 6'b000000, 2'd3, ro, rzr, rng, lat, st);
        n_total++; if (ro !== 16'h0800) $display("FAIL shr4 got=%h exp=0800", ro); else n_pass++;
        n_total++; if (lat != 4) $display("FAIL shr4_lat got=%0d exp=4", lat); else n_pass++;
        run_cmd(16'h1234, 16'd0, 6'b000000, 2'd2, ro, rzr, rng, lat, st);
        n_total++; if (ro !== 16'h1234) $display("FAIL shl0 got=%h exp=1234", ro); else n_pass++;
        n_total++; if (lat != 1) $display("FAIL shl0_lat got=%0d exp=1", lat); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held;
        bit ok;
        drive_cmd(16'd10, 16'd20, 6'b000010, 2'd0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        n_total++; if ({out_valid, out} !== {1'b1, 16'd30}) $display("FAIL bp_result got v=%b out=%h exp v=1 out=001e", out_valid, out); else n_pass++;
        held = out;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (out !== held || out_valid !== 1'b1 || in_ready !== 1'b0) ok = 1'b0;
        end
        n_total++; if (ok !== 1'b1) $display("FAIL bp_hold got_ok=%b exp=1 out=%h in_ready=%b", ok, out, in_ready); else n_pass++;
        drive_cmd(16'd100, 16'd23, 6'b000010, 2'd0);
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); else n_pass++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_total++; if ({out_valid, out} !== {1'b1, 16'd123}) $display("FAIL back_to_back got v=%b out=%h exp v=1 out=007b", out_valid, out); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int n_ok = 0;
        logic [W-1:0] a [4];
        logic [W-1:0] b [4];
        for (int i = 0; i < 4; i++) begin a[i] = W'($urandom); b[i] = W'($urandom); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_cmd(a[i], b[i], 6'b000010, 2'd0);
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(posedge clk); #1;
            if (out_valid === 1'b1 && out === W'(a[i] + b[i])) n_ok++;
        end
        n_total++; if (n_ok != 4) $display("FAIL hack_stream got=%0d exp=4 good results", n_ok); else n_pass++;
    endtask

    task automatic test_reset_mid_mul();
        logic [W-1:0] ro; logic rzr, rng; int lat; bit st;
        drive_cmd(16'd300, 16'd300, 6'b000000, 2'd1);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_total++; if ({out_valid, out, in_ready} !== {1'b0, 16'h0000, 1'b1})
            $display("FAIL reset_mid_mul got v=%b out=%h rdy=%b exp v=0 out=0000 rdy=1", out_valid, out, in_ready);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        run_cmd(16'd7, 16'd9, 6'b000010, 2'd0, ro, rzr, rng, lat, st);
        n_total++; if (ro !== 16'd16 || lat != 1) $display("FAIL after_reset_hack got=%h lat=%0d exp=0010 lat=1", ro, lat); else n_pass++;
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, ro, exp_r; logic [5:0] ctl; logic [1:0] o;
        logic rzr, rng; int lat, exp_l; bit st;
        for (int i = 0; i < 40; i++) begin
            a = W'($urandom); b = W'($urandom); ctl = 6'($urandom); o = 2'($urandom);
            if (i % 5 == 0) a = 16'h0000;
            exp_r = ref_result(a, b, ctl, o);
            exp_l = ref_latency(b, ctl, o);
            run_cmd(a, b, ctl, o, ro, rzr, rng, lat, st);
            n_total++;
            if (ro !== exp_r || lat != exp_l || rzr !== (exp_r == '0) || rng !== exp_r[W-1])
                $display("FAIL random[%0d] op=%0d ctl=%b x=%h y=%h got=%h lat=%0d zr=%b ng=%b exp=%h lat=%0d",
                         i, o, ctl, a, b, ro, lat, rzr, rng, exp_r, exp_l);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_hack();
        test_mul();
        test_shift();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mul();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
